mips32_fetch_unit: RTL



---
 rtl/mips32_fetch_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mips32_fetch_unit.sv
// Instruction fetch stage: variable-latency imem req/ack handshake feeding a small
// prefetch FIFO that presents {instruction, PC} pairs to decode via valid/ready.
module mips32_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [29:0]   fpc_reg, fpc_next;
  logic [29:0]   target_reg, target_next;
  logic [CW-1:0] count_reg, count_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;

  logic [31:0] instr_mem [DEPTH];
  logic [29:0] pc_mem    [DEPTH];

  logic        push;
  logic        pop;
  logic        room;
  logic [29:0] redirect_wa;
  logic        unused_pc_bits;

  // PCs are kept as word addresses; the byte offset of a redirect target is dropped.
  assign redirect_wa    = redirect_pc[31:2];
  assign unused_pc_bits = ^redirect_pc[1:0];

  assign push = (state_reg == FETCH) && imem_ack && !redirect;
  assign pop  = id_valid && id_ready && !redirect;

  always_comb begin
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (redirect) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      count_next = count_reg + CW'(push) - CW'(pop);
      if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
    end
  end

  assign room = (count_next < DEPTH_C);

  always_comb begin
    state_next  = state_reg;
    fpc_next    = fpc_reg;
    target_next = target_reg;
    case (state_reg)
      IDLE: begin
        if (redirect) begin
          fpc_next   = redirect_wa;
          state_next = FETCH;
        end else if (room) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (redirect) begin
          if (imem_ack) begin
            fpc_next = redirect_wa;
          end else begin
            // Outstanding request must still complete; its data will be dropped.
            target_next = redirect_wa;
            state_next  = DRAIN;
          end
        end else if (imem_ack) begin
          fpc_next   = fpc_reg + 30'd1;
          state_next = room ? FETCH : IDLE;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          fpc_next   = redirect ? redirect_wa : target_reg;
          state_next = FETCH;
        end else if (redirect) begin
          target_next = redirect_wa;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      fpc_reg    <= RESET_PC[31:2];
      target_reg <= RESET_PC[31:2];
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      fpc_reg    <= fpc_next;
      target_reg <= target_next;
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= imem_data;
      pc_mem[wr_ptr_reg]    <= fpc_reg;
    end
  end

  assign imem_req  = (state_reg != IDLE);
  assign imem_addr = fpc_reg;
  assign id_valid  = (count_reg != '0);
  assign id_instr  = instr_mem[rd_ptr_reg];
  assign id_pc     = {pc_mem[rd_ptr_reg], 2'b00};

endmodule
